// File: rtl/ram_read_port_pkg.sv
// rtl/ram_read_port_pkg.sv - shared constants, FSM states and decode helper for the RAM read port
package ram_read_port_pkg;

    localparam int RAM_WORDS = 16;
    localparam int RAM_AW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_HOLD   = 2'd2
    } rd_state_e;

    function automatic logic [RAM_WORDS-1:0] onehot16(input logic [RAM_AW-1:0] addr);
        return RAM_WORDS'(1) << addr;
    endfunction

endpackage

// File: rtl/mux16.sv
// rtl/mux16.sv - combinational 16:1 word mux, read-side mirror of the write-enable demux
module mux16
    import ram_read_port_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [RAM_WORDS*WIDTH-1:0] words,
    input  logic [RAM_AW-1:0]          sel,
    output logic [WIDTH-1:0]           data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < RAM_WORDS; i++) begin
            if (sel == RAM_AW'(i)) begin
                data = words[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/ram_read_port.sv
// rtl/ram_read_port.sv - read-side controller: req/busy accept, one-hot select for READ_LAT cycles, capture and hold
module ram_read_port
    import ram_read_port_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int READ_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req,
    input  logic [RAM_AW-1:0]          rd_addr,
    output logic                       rd_busy,
    output logic [RAM_WORDS-1:0]       rd_sel,
    input  logic [RAM_WORDS*WIDTH-1:0] word_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready
);

    localparam logic [RAM_AW-1:0] LAT_LAST = RAM_AW'(READ_LAT - 1);

    rd_state_e              state_q,    state_d;
    logic [RAM_AW-1:0]      addr_q,     addr_d;
    logic [RAM_AW-1:0]      lat_cnt_q,  lat_cnt_d;
    logic [RAM_WORDS-1:0]   rd_sel_q,   rd_sel_d;
    logic [WIDTH-1:0]       rd_data_q,  rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]       mux_data;

    mux16 #(.WIDTH(WIDTH)) u_mux16 (
        .words (word_data),
        .sel   (addr_q),
        .data  (mux_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lat_cnt_d  = lat_cnt_q;
        rd_sel_d   = rd_sel_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    addr_d    = rd_addr;
                    lat_cnt_d = '0;
                    rd_sel_d  = onehot16(rd_addr);
                    state_d   = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // rd_sel was loaded on accept so it is live for exactly READ_LAT cycles
                lat_cnt_d = lat_cnt_q + 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    rd_data_d  = mux_data;
                    rd_valid_d = 1'b1;
                    rd_sel_d   = '0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (rd_req) begin
                        addr_d    = rd_addr;
                        lat_cnt_d = '0;
                        rd_sel_d  = onehot16(rd_addr);
                        state_d   = ST_SELECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                rd_sel_d   = '0;
                rd_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            lat_cnt_q  <= '0;
            rd_sel_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_sel_q   <= rd_sel_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_busy  = (state_q != ST_IDLE);
    assign rd_sel   = rd_sel_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_read_port.sv
// tb/tb_ram_read_port.sv - directed bench for ram_read_port at READ_LAT=1 and READ_LAT=3
module tb_ram_read_port;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] word_data;
    logic [7:0]   w_tbl [16];

    logic         req1, ready1, busy1, valid1;
    logic [3:0]   addr1;
    logic [15:0]  sel1;
    logic [7:0]   data1;

    logic         req3, ready3, busy3, valid3;
    logic [3:0]   addr3;
    logic [15:0]  sel3;
    logic [7:0]   data3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 16; g++) begin : g_words
        assign word_data[g*8 +: 8] = w_tbl[g];
    end

    ram_read_port #(.WIDTH(8), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst), .rd_req(req1), .rd_addr(addr1), .rd_busy(busy1),
        .rd_sel(sel1), .word_data(word_data), .rd_data(data1), .rd_valid(valid1),
        .rd_ready(ready1)
    );

    ram_read_port #(.WIDTH(8), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .rd_req(req3), .rd_addr(addr3), .rd_busy(busy3),
        .rd_sel(sel3), .word_data(word_data), .rd_data(data3), .rd_valid(valid3),
        .rd_ready(ready3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic read1(input logic [3:0] a, input logic [7:0] exp);
        int n;
        req1 = 1'b1; addr1 = a;
        @(negedge clk);
        req1 = 1'b0; addr1 = 4'h0;
        n = 0;
        while (!valid1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("sweep_valid", {31'd0, valid1}, 32'd1);
        check("sweep_data", {24'd0, data1}, {24'd0, exp});
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check("sweep_idle", {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        w_tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA5, 8'h66, 8'h77,
                  8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h3C};
        rst = 1'b1;
        req1 = 0; addr1 = 0; ready1 = 0;
        req3 = 0; addr3 = 0; ready3 = 0;
        repeat (2) @(negedge clk);
        check("rst_sel", {16'd0, sel1}, 32'h0);
        check("rst_valid", {31'd0, valid1}, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_data", {24'd0, data1}, 32'h0);
        check("rst_busy3", {31'd0, busy3}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // reset asserted mid-SELECT
        req1 = 1'b1; addr1 = 4'd3;
        @(negedge clk);
        req1 = 1'b0;
        check("pre_rst_sel", {16'd0, sel1}, 32'h0008);
        #2 rst = 1'b1;
        #1;
        check("async_sel", {16'd0, sel1}, 32'h0);
        check("async_valid", {31'd0, valid1}, 32'd0);
        check("async_busy", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy1}, 32'd0);
        check("post_rst_valid", {31'd0, valid1}, 32'd0);

        // single read of word 5
        req1 = 1'b1; addr1 = 4'd5;
        @(negedge clk);
        req1 = 1'b0;
        check("single_sel", {16'd0, sel1}, 32'h0020);
        check("single_valid_early", {31'd0, valid1}, 32'd0);
        check("single_busy", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        check("single_valid", {31'd0, valid1}, 32'd1);
        check("single_data", {24'd0, data1}, 32'hA5);
        check("single_sel_off", {16'd0, sel1}, 32'h0);

        // hold with rd_ready low; rd_req ignored while holding
        for (int i = 0; i < 10; i++) begin
            req1 = (i == 4); addr1 = 4'd7;
            @(negedge clk);
            check("hold_data", {24'd0, data1}, 32'hA5);
            check("hold_valid", {31'd0, valid1}, 32'd1);
            check("hold_busy", {31'd0, busy1}, 32'd1);
        end
        req1 = 1'b0;
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check("release_valid", {31'd0, valid1}, 32'd0);
        check("release_busy", {31'd0, busy1}, 32'd0);

        // back-to-back: re-read word 5, then accept + request word 15 in the same cycle
        req1 = 1'b1; addr1 = 4'd5;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        check("b2b_first_data", {24'd0, data1}, 32'hA5);
        ready1 = 1'b1; req1 = 1'b1; addr1 = 4'd15;
        @(negedge clk);
        ready1 = 1'b0; req1 = 1'b0; addr1 = 4'd0;
        check("b2b_sel", {16'd0, sel1}, 32'h8000);
        check("b2b_busy", {31'd0, busy1}, 32'd1);
        check("b2b_valid_drop", {31'd0, valid1}, 32'd0);
        @(negedge clk);
        check("b2b_valid", {31'd0, valid1}, 32'd1);
        check("b2b_data", {24'd0, data1}, 32'h3C);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check("b2b_idle", {31'd0, busy1}, 32'd0);

        // READ_LAT=3: select held exactly three cycles
        req3 = 1'b1; addr3 = 4'd0;
        @(negedge clk);
        req3 = 1'b0;
        check("lat3_sel_c1", {16'd0, sel3}, 32'h0001);
        @(negedge clk);
        check("lat3_sel_c2", {16'd0, sel3}, 32'h0001);
        check("lat3_valid_c2", {31'd0, valid3}, 32'd0);
        @(negedge clk);
        check("lat3_sel_c3", {16'd0, sel3}, 32'h0001);
        check("lat3_valid_c3", {31'd0, valid3}, 32'd0);
        @(negedge clk);
        check("lat3_sel_c4", {16'd0, sel3}, 32'h0);
        check("lat3_valid_c4", {31'd0, valid3}, 32'd1);
        check("lat3_data", {24'd0, data3}, 32'h11);
        ready3 = 1'b1;
        @(negedge clk);
        ready3 = 1'b0;
        check("lat3_idle", {31'd0, busy3}, 32'd0);

        // request pulsed during SELECT is dropped
        req1 = 1'b1; addr1 = 4'd2;
        @(negedge clk);
        addr1 = 4'd9;
        @(negedge clk);
        req1 = 1'b0; addr1 = 4'd0;
        check("drop_data", {24'd0, data1}, 32'h33);
        check("drop_valid", {31'd0, valid1}, 32'd1);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check("drop_idle", {31'd0, busy1}, 32'd0);
        check("drop_sel", {16'd0, sel1}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            read1(4'(i), w_tbl[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
